irq_ctrl: RTL and testbench

Interrupt controller that multiplexes up to eight external interrupt sources onto the single interrupt request consumed by the CP0 exception logic. It latches, masks and prioritises the sources, then presents one request with a source id. It holds that request until the pipeline takes it, and blocks further requests until ERET. It sits between the board-level interrupt lines and the CP0 `ir_in` input, with a small register window written from the EXE stage.

---
 rtl/irq_ctrl_pkg.sv | 16 +
 rtl/irq_prio_enc.sv | 30 +++
 rtl/irq_ctrl.sv | 122 ++++++++++++
 tb/tb_irq_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the interrupt controller: register window
// addresses, FSM state codes and the id width.
package irq_ctrl_pkg;
    localparam int IRQ_IDW = 3;

    localparam logic [1:0] IRQ_MASK = 2'd0;
    localparam logic [1:0] IRQ_EDGE = 2'd1;
    localparam logic [1:0] IRQ_PEND = 2'd2;
    localparam logic [1:0] IRQ_STAT = 2'd3;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;
endpackage

// File: rtl/irq_prio_enc.sv
// Picks the first eligible source, searching upward from a start pointer and
// wrapping at N_SRC. A start of 0 gives plain lowest-index priority.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0]   elig,
    input  logic [IRQ_IDW-1:0] start,
    output logic               vld,
    output logic [IRQ_IDW-1:0] idx
);
    always_comb begin
        int p;
        logic [N_SRC-1:0] sh;
        vld = 1'b0;
        idx = '0;
        p   = 0;
        sh  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            p = int'(start) + k;
            if (p >= N_SRC) p = p - N_SRC;
            sh = elig >> p;
            if (!vld && sh[0]) begin
                vld = 1'b1;
                idx = p[IRQ_IDW-1:0];
            end
        end
    end
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches, masks and prioritises up to N_SRC sources
// into a single CP0 request. Define IRQ_ROUND_ROBIN_EN for round-robin arbitration.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SRC-1:0]   src_in,
    input  logic               ir_taken,
    input  logic               eret,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               ir_req,
    output logic [IRQ_IDW-1:0] ir_id
);
    irq_state_e         state_q, state_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [N_SRC-1:0]   edge_q, edge_d;
    logic [N_SRC-1:0]   epend_q, epend_d;
    logic [N_SRC-1:0]   src_q;
    logic [IRQ_IDW-1:0] id_q, id_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ir_req_q, ir_req_d;
    logic [N_SRC-1:0]   pend, elig, clr;
    logic [IRQ_IDW-1:0] start, win_id;
    logic               win_vld, take;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata[31:N_SRC];

    // Level sources bypass the latch and follow the line directly.
    assign pend = (edge_q & epend_q) | (~edge_q & src_in);
    assign elig = pend & mask_q;
    assign take = (state_q == IRQ_REQ) && ir_taken;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IRQ_IDW-1:0] rr_ptr_q, rr_ptr_d;
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (take) rr_ptr_d = (id_q == IRQ_IDW'(N_SRC - 1)) ? '0 : id_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
    assign start = rr_ptr_q;
`else
    assign start = '0;
`endif

    irq_prio_enc #(.N_SRC(N_SRC)) u_enc (
        .elig (elig),
        .start(start),
        .vld  (win_vld),
        .idx  (win_id)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE:    if (win_vld) state_d = IRQ_REQ;
            IRQ_REQ: begin
                if (ir_taken)        state_d = IRQ_SERVICE;
                else if (!elig[id_q]) state_d = IRQ_IDLE;
            end
            IRQ_SERVICE: if (eret) state_d = IRQ_IDLE;
            default:     state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        id_d     = (state_q == IRQ_IDLE && win_vld) ? win_id : id_q;
        ir_req_d = (state_d == IRQ_REQ);
    end

    always_comb begin
        mask_d  = mask_q;
        edge_d  = edge_q;
        clr     = take ? (N_SRC'(1) << id_q) : '0;
        if (cfg_we && cfg_addr == IRQ_MASK) mask_d = cfg_wdata[N_SRC-1:0];
        if (cfg_we && cfg_addr == IRQ_EDGE) edge_d = cfg_wdata[N_SRC-1:0];
        if (cfg_we && cfg_addr == IRQ_PEND) clr = clr | cfg_wdata[N_SRC-1:0];
        // A new rising edge in the same cycle as a clear keeps the bit set.
        epend_d = (edge_q & src_in & ~src_q) | (epend_q & ~clr);
        case (cfg_addr)
            IRQ_MASK: rdata_d = 32'(mask_q);
            IRQ_EDGE: rdata_d = 32'(edge_q);
            IRQ_PEND: rdata_d = 32'(pend);
            default:  rdata_d = {27'd0, id_q, state_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IRQ_IDLE;
            mask_q   <= '0;
            edge_q   <= '0;
            epend_q  <= '0;
            src_q    <= '0;
            id_q     <= '0;
            rdata_q  <= '0;
            ir_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            epend_q  <= epend_d;
            src_q    <= src_in;
            id_q     <= id_d;
            rdata_q  <= rdata_d;
            ir_req_q <= ir_req_d;
        end
    end

    assign ir_req    = ir_req_q;
    assign ir_id     = id_q;
    assign cfg_rdata = rdata_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with a cycle-level behavioural model checked
// after every clock, plus literal expectations from hand-worked scenarios.
module tb_irq_ctrl;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  src_in = '0;
    logic        ir_taken = 1'b0, eret = 1'b0, cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        ir_req;
    logic [2:0]  ir_id;

    always #5 clk = ~clk;

    irq_ctrl #(.N_SRC(N)) dut (
        .clk(clk), .rst_n(rst_n), .src_in(src_in), .ir_taken(ir_taken), .eret(eret),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .ir_req(ir_req), .ir_id(ir_id)
    );

    // Model: state 0 idle, 1 requesting, 2 in service.
    int          m_state = 0, m_id = 0, m_ptr = 0;
    bit [7:0]    m_mask = '0, m_edge = '0, m_ep = '0, m_prev = '0;
    logic [31:0] m_rd = '0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [7:0] m_pend();
        bit [7:0] p;
        for (int i = 0; i < N; i++) p[i] = m_edge[i] ? m_ep[i] : src_in[i];
        return p;
    endfunction

    function automatic int m_pick(input bit [7:0] e, input int ptr);
        for (int k = 0; k < N; k++)
            if (e[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_step();
        bit [7:0] pend, elig, clr;
        int nstate, nid, nptr, w;
        if (!rst_n) begin
            m_state = 0; m_id = 0; m_ptr = 0; m_mask = '0; m_edge = '0;
            m_ep = '0; m_prev = '0; m_rd = '0;
            return;
        end
        pend = m_pend();
        elig = pend & m_mask;
        case (cfg_addr)
            2'd0: m_rd = 32'(m_mask);
            2'd1: m_rd = 32'(m_edge);
            2'd2: m_rd = 32'(pend);
            default: m_rd = 32'(m_id * 4 + m_state);
        endcase
        nstate = m_state; nid = m_id; nptr = m_ptr; clr = '0;
        if (m_state == 0) begin
            w = m_pick(elig, m_ptr);
            if (w >= 0) begin nid = w; nstate = 1; end
        end else if (m_state == 1) begin
            if (ir_taken) begin
                nstate = 2;
                clr[m_id] = 1'b1;
`ifdef IRQ_ROUND_ROBIN_EN
                nptr = (m_id + 1) % N;
`endif
            end else if (!elig[m_id]) nstate = 0;
        end else if (eret) nstate = 0;
        if (cfg_we && cfg_addr == 2'd2) clr = clr | cfg_wdata[7:0];
        for (int i = 0; i < N; i++) begin
            if (m_edge[i] && src_in[i] && !m_prev[i]) m_ep[i] = 1'b1;
            else if (clr[i]) m_ep[i] = 1'b0;
        end
        if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[7:0];
        if (cfg_we && cfg_addr == 2'd1) m_edge = cfg_wdata[7:0];
        m_prev = src_in;
        m_state = nstate; m_id = nid; m_ptr = nptr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("ir_req", 32'(ir_req), 32'(m_state == 1));
        chk("ir_id", 32'(ir_id), 32'(m_id));
        chk("cfg_rdata", cfg_rdata, m_rd);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_req", 32'(ir_req), 0);
        chk("rst_rdata", cfg_rdata, 0);
        rst_n = 1'b1;
    endtask

    int exp_rr[3];
    int waited;

    initial begin
`ifdef IRQ_ROUND_ROBIN_EN
        exp_rr = '{0, 4, 0};
`else
        exp_rr = '{0, 0, 0};
`endif
        #1;
        do_reset();
        chk("rst_id", 32'(ir_id), 0);

        // Level sources 3 and 5: lowest index wins
        wr(2'd0, 32'hFF);
        cfg_addr = 2'd3; src_in = 8'h28;
        tick(); tick();
        chk("lvl_req", 32'(ir_req), 1);
        chk("lvl_id", 32'(ir_id), 3);
        chk("lvl_stat", cfg_rdata, 32'd13);
        src_in = 8'h00; tick(); tick();

        // Edge source 0: one-cycle pulse latches
        wr(2'd1, 32'h01);
        src_in = 8'h01; tick();
        src_in = 8'h00; cfg_addr = 2'd2; tick();
        chk("edge_pend", cfg_rdata, 32'h01);
        chk("edge_req", 32'(ir_req), 1);
        chk("edge_id", 32'(ir_id), 0);
        ir_taken = 1'b1; tick(); ir_taken = 1'b0;
        chk("taken_req", 32'(ir_req), 0);
        tick();
        chk("taken_pend", cfg_rdata, 32'h00);
        cfg_addr = 2'd3; tick();
        chk("svc_stat", cfg_rdata, 32'd2);
        eret = 1'b1; tick(); eret = 1'b0; tick();
        chk("eret_stat", cfg_rdata, 32'd0);

        // Level withdrawal before take
        src_in = 8'h04; tick();
        src_in = 8'h00; tick();
        chk("wd_req", 32'(ir_req), 0);
        tick();
        chk("wd_stat", cfg_rdata, 32'd8);

        // Arrival during service is held off until after eret
        src_in = 8'h04; tick();
        ir_taken = 1'b1; tick(); ir_taken = 1'b0;
        src_in = 8'h02;
        repeat (4) tick();
        chk("svc_hold", 32'(ir_req), 0);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("eret_norq", 32'(ir_req), 0);
        tick();
        chk("post_eret_req", 32'(ir_req), 1);
        chk("post_eret_id", 32'(ir_id), 1);
        src_in = 8'h00; ir_taken = 1'b1; tick(); ir_taken = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0; tick();

        // Take coincident with withdrawal enters service
        src_in = 8'h04; tick();
        src_in = 8'h00; ir_taken = 1'b1; tick(); ir_taken = 1'b0;
        tick();
        chk("take_wd_stat", cfg_rdata, 32'd10);
        eret = 1'b1; tick(); eret = 1'b0; tick();

        // Edge re-rise coincident with the take clear
        cfg_addr = 2'd2;
        src_in = 8'h01; tick();
        src_in = 8'h00; tick();
        src_in = 8'h01; ir_taken = 1'b1; tick(); ir_taken = 1'b0;
        src_in = 8'h00; tick();
        chk("rerise_pend", cfg_rdata, 32'h01);
        chk("rerise_req", 32'(ir_req), 0);
        eret = 1'b1; tick(); eret = 1'b0; tick();
        ir_taken = 1'b1; tick(); ir_taken = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0; tick();

        // Arbitration across rounds with sources 0 and 4 held
        do_reset();
        wr(2'd0, 32'hFF);
        src_in = 8'h11;
        for (int r = 0; r < 3; r++) begin
            waited = 0;
            while (!ir_req && waited < 10) begin tick(); waited++; end
            chk("rr_wait", 32'(ir_req), 1);
            chk($sformatf("rr_id%0d", r), 32'(ir_id), 32'(exp_rr[r]));
            ir_taken = 1'b1; tick(); ir_taken = 1'b0;
            eret = 1'b1; tick(); eret = 1'b0;
        end
        src_in = 8'h00; tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
